// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU controller: state encodings,
// primary opcodes, PC/writeback select codes and instruction classes.
package cpu_pkg;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    localparam logic [3:0] OP_ALUR  = 4'b0000;
    localparam logic [3:0] OP_ALUI  = 4'b1000;
    localparam logic [3:0] OP_CMPR  = 4'b0010;
    localparam logic [3:0] OP_CMPI  = 4'b1010;
    localparam logic [3:0] OP_BCOND = 4'b0110;
    localparam logic [3:0] OP_SW    = 4'b0101;
    localparam logic [3:0] OP_LW    = 4'b1001;
    localparam logic [3:0] OP_JAL   = 4'b1011;

    localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_JAL    = 2'b10;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_LINK = 2'b10;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_CMP,
        CLS_BCOND,
        CLS_STORE,
        CLS_LOAD,
        CLS_JAL,
        CLS_ILLEGAL
    } instr_class_e;

    function automatic logic is_mem_class(input instr_class_e cls);
        return (cls == CLS_STORE) || (cls == CLS_LOAD);
    endfunction

endpackage

// File: rtl/cpu_decode.sv
// Purely combinational primary-opcode decoder: instruction class, legality
// and whether the ALU B operand comes from the immediate field.
module cpu_decode
    import cpu_pkg::*;
(
    input  logic [3:0]   op1_i,
    output instr_class_e cls_o,
    output logic         legal_o,
    output logic         src_imm_o
);

    always_comb begin
        cls_o     = CLS_ILLEGAL;
        legal_o   = 1'b1;
        src_imm_o = 1'b0;
        case (op1_i)
            OP_ALUR:  cls_o = CLS_ALU;
            OP_ALUI: begin
                cls_o     = CLS_ALU;
                src_imm_o = 1'b1;
            end
            OP_CMPR:  cls_o = CLS_CMP;
            OP_CMPI: begin
                cls_o     = CLS_CMP;
                src_imm_o = 1'b1;
            end
            OP_BCOND: cls_o = CLS_BCOND;
            OP_SW: begin
                cls_o     = CLS_STORE;
                src_imm_o = 1'b1;
            end
            OP_LW: begin
                cls_o     = CLS_LOAD;
                src_imm_o = 1'b1;
            end
            OP_JAL: begin
                cls_o     = CLS_JAL;
                src_imm_o = 1'b1;
            end
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_control.sv
// Multi-cycle CPU control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT) with
// memory-mapped I/O handshake, I/O timeout and a retired-instruction counter.
module cpu_control
    import cpu_pkg::*;
#(
    parameter int DBITS      = 32,
    parameter int IO_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      inst_word,
    input  logic             cond_true,
    input  logic             addr_is_io,
    input  logic             io_ack,
    output logic             ir_wr_en,
    output logic             pc_wr_en,
    output logic [1:0]       pc_sel,
    output logic [7:0]       alu_op,
    output logic             alu_src_imm,
    output logic             rf_wr_en,
    output logic [1:0]       wb_sel,
    output logic             dmem_we,
    output logic             io_req,
    output logic             io_we,
    output logic [2:0]       state,
    output logic             halted,
    output logic             bus_err,
    output logic [DBITS-1:0] retired
);

    localparam int WAIT_W = $clog2(IO_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(IO_TIMEOUT - 1);

    logic [2:0]        state_q, state_d;
    logic [7:0]        ir_q;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              halted_q, halted_d;
    logic              bus_err_q, bus_err_d;
    logic [DBITS-1:0]  retired_q;

    instr_class_e cls;
    logic         legal;
    logic         src_imm;
    logic         mem_done;
    logic         unused_inst_bits;

    // Only the opcode byte drives control; the operand fields go to the datapath.
    assign unused_inst_bits = ^inst_word[23:0];

    cpu_decode u_decode (
        .op1_i     (ir_q[7:4]),
        .cls_o     (cls),
        .legal_o   (legal),
        .src_imm_o (src_imm)
    );

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        halted_d    = halted_q;
        bus_err_d   = bus_err_q;
        ir_wr_en    = 1'b0;
        pc_wr_en    = 1'b0;
        pc_sel      = PC_SEL_SEQ;
        alu_src_imm = 1'b0;
        rf_wr_en    = 1'b0;
        wb_sel      = WB_SEL_ALU;
        dmem_we     = 1'b0;
        io_req      = 1'b0;
        io_we       = 1'b0;
        mem_done    = 1'b0;

        case (state_q)
            ST_FETCH: begin
                // Reset parks the FSM in FETCH; keep the IR strobe quiet until released.
                ir_wr_en = reset;
                state_d  = ST_DECODE;
            end
            ST_DECODE: begin
                alu_src_imm = src_imm;
                if (legal) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end
            end
            ST_EXEC: begin
                alu_src_imm = src_imm;
                if (cls == CLS_BCOND) begin
                    pc_wr_en = 1'b1;
                    pc_sel   = cond_true ? PC_SEL_BRANCH : PC_SEL_SEQ;
                    state_d  = ST_FETCH;
                end else if (is_mem_class(cls)) begin
                    wait_d  = '0;
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                alu_src_imm = src_imm;
                if (addr_is_io) begin
                    io_req = 1'b1;
                    io_we  = (cls == CLS_STORE);
                    // An ack arriving on the expiry cycle still wins over the timeout.
                    if (io_ack) begin
                        mem_done = 1'b1;
                    end else if (wait_q == WAIT_LAST) begin
                        bus_err_d = 1'b1;
                        state_d   = ST_HALT;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end else begin
                    mem_done = 1'b1;
                end
                if (mem_done) begin
                    if (cls == CLS_STORE) begin
                        dmem_we  = ~addr_is_io;
                        pc_wr_en = 1'b1;
                        state_d  = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                alu_src_imm = src_imm;
                rf_wr_en    = 1'b1;
                pc_wr_en    = 1'b1;
                if (cls == CLS_LOAD) begin
                    wb_sel = WB_SEL_LOAD;
                end else if (cls == CLS_JAL) begin
                    wb_sel = WB_SEL_LINK;
                    pc_sel = PC_SEL_JAL;
                end
                state_d = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_FETCH;
            ir_q      <= '0;
            wait_q    <= '0;
            halted_q  <= 1'b0;
            bus_err_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            halted_q  <= halted_d;
            bus_err_q <= bus_err_d;
            if (ir_wr_en) begin
                ir_q <= inst_word[31:24];
            end
            if (pc_wr_en) begin
                retired_q <= retired_q + DBITS'(1);
            end
        end
    end

    assign alu_op  = ir_q;
    assign state   = state_q;
    assign halted  = halted_q;
    assign bus_err = bus_err_q;
    assign retired = retired_q;

endmodule

// File: doc/cpu_control.md
CPU_CONTROL -- requirements
Module: cpu_control

Interface
REQ-001 Parameter DBITS, default 32, datapath word width (retire counter width).
REQ-002 Parameter IO_TIMEOUT, default 15, maximum io_ack wait cycles before bus error.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 inst_word  input  32  instruction from instruction memory; op1=inst_word[31:28], op2=inst_word[27:24].
REQ-006 cond_true  input  1  branch condition result from ALU compare, valid in EXEC.
REQ-007 addr_is_io  input  1  effective address >= 32'hF0000000, valid in MEM.
REQ-008 io_ack  input  1  memory-mapped I/O completion.
REQ-009 ir_wr_en  output  1  latch inst_word into instruction register.
REQ-010 pc_wr_en  output  1  PC write strobe.
REQ-011 pc_sel  output  2  00 PC+4, 01 branch target, 10 JAL target.
REQ-012 alu_op  output  8  {op1,op2} of latched instruction.
REQ-013 alu_src_imm  output  1  ALU B operand is immediate.
REQ-014 rf_wr_en  output  1  register-file write strobe.
REQ-015 wb_sel  output  2  00 ALU result, 01 load data, 10 PC+4.
REQ-016 dmem_we  output  1  data-memory write strobe.
REQ-017 io_req, io_we  output  1 each  I/O request and write qualifier.
REQ-018 state  output  3  current FSM state encoding.
REQ-019 halted, bus_err  output  1 each  sticky illegal-opcode halt and I/O timeout flag.
REQ-020 retired  output  DBITS  count of completed instructions.

Function
REQ-021 FSM states SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
REQ-022 FETCH: ir_wr_en=1 for one cycle; next DECODE.
REQ-023 DECODE: op1 in {ALUR 0000, ALUI 1000, CMPR 0010, CMPI 1010, BCOND 0110, SW 0101, LW 1001, JAL 1011} -> EXEC; any other op1 -> HALT with halted=1.
REQ-024 alu_src_imm SHALL be 1 for ALUI, CMPI, SW, LW, JAL; 0 otherwise; held from DECODE through WB.
REQ-025 EXEC: ALUR/ALUI/CMPR/CMPI/JAL -> WB; LW/SW -> MEM; BCOND asserts pc_wr_en with pc_sel=01 if cond_true else 00, -> FETCH.
REQ-026 MEM non-I/O: SW asserts dmem_we and pc_wr_en (pc_sel=00) one cycle -> FETCH; LW -> WB.
REQ-027 MEM I/O: io_req=1 (io_we=1 for SW) held until io_ack sampled high; completion then as REQ-026; dmem_we never asserted for I/O addresses.
REQ-028 I/O wait counter SHALL reset on MEM entry; if IO_TIMEOUT cycles pass without io_ack, drop io_req, set bus_err=1, -> HALT.
REQ-029 WB: rf_wr_en=1, pc_wr_en=1 one cycle; wb_sel=01 for LW, 10 for JAL, else 00; pc_sel=10 for JAL, else 00; -> FETCH.
REQ-030 Latency: BCOND 3 cycles, ALU/CMP/JAL 4, non-I/O SW 4, non-I/O LW 5, I/O adds ack wait cycles.
REQ-031 retired SHALL increment by 1 in each cycle pc_wr_en=1, wrapping from all-ones to 0.
REQ-032 io_ack outside MEM-with-io_req SHALL be ignored; io_ack in same cycle as timeout expiry counts as success.
REQ-033 HALT: all strobes 0 until reset; halted/bus_err remain set.
REQ-034 At most one of rf_wr_en, dmem_we, io_req asserted per cycle.

Reset
REQ-035 reset low SHALL immediately force state=FETCH, all strobes/selects 0, alu_op=0, retired=0, halted=0, bus_err=0, wait counter 0, including mid-instruction or mid-I/O wait.
REQ-036 First FETCH occurs on the first rising edge after reset deasserts.

Structure
REQ-037 Opcode constants, state encodings, pc_sel/wb_sel codes SHALL reside in shared package cpu_pkg.
REQ-038 Combinational sub-module cpu_decode SHALL map op1 to instruction class, legality and alu_src_imm.

Verification
REQ-039 ALUR (op1=0000, op2=0000) after reset -> ir_wr_en cycle 1, rf_wr_en+pc_wr_en cycle 4, wb_sel=00, retired=1.
REQ-040 BCOND with cond_true=1 then cond_true=0 -> pc_wr_en in cycle 3 with pc_sel=01 then 00; rf_wr_en never high; retired=2.
REQ-041 SW to I/O, io_ack after 3 cycles -> io_req,io_we high 3 cycles, dmem_we=0, pc_wr_en on ack cycle.
REQ-042 LW to I/O, io_ack never -> io_req dropped after 15 cycles, bus_err=1, state=5, no further strobes.
REQ-043 op1=1111 -> halted=1, state=5 after DECODE; reset low -> state=0, halted=0, retired=0.
REQ-044 reset asserted during WB of JAL -> no rf_wr_en/pc_wr_en on that edge; outputs 0 immediately.
